// File: rtl/sequenciador_ula.sv
// Accumulator-based command sequencer for the 8-bit ALU: registers operands/opcode,
// waits a fixed settle time, captures result and flags, and hands them out on a valid/ready port.
module sequenciador_ula #(
  parameter int LATENCIA_ULA = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Cmd_Valido,
  output logic        Cmd_Pronto,
  input  logic [3:0]  Cmd_Op,
  input  logic [1:0]  Cmd_Fonte,
  input  logic [7:0]  Cmd_Dado,
  output logic [7:0]  ULA_A,
  output logic [7:0]  ULA_B,
  output logic [3:0]  ULA_Sel,
  input  logic [15:0] ULA_Resultado,
  input  logic        ULA_Maior,
  input  logic        ULA_Menor,
  input  logic        ULA_Igual,
  output logic        Res_Valido,
  input  logic        Res_Pronto,
  output logic [15:0] Res_Dado,
  output logic [2:0]  Res_Flags,
  output logic        Res_Erro,
  output logic [7:0]  Acc
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, ENTREGA} estado_t;

  localparam logic [3:0] LAT_CNT = 4'(LATENCIA_ULA);

  estado_t     state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  acc_reg, acc_next;
  logic [7:0]  ula_a_reg, ula_a_next;
  logic [7:0]  ula_b_reg, ula_b_next;
  logic [3:0]  ula_sel_reg, ula_sel_next;
  logic [15:0] res_dado_reg, res_dado_next;
  logic [2:0]  res_flags_reg, res_flags_next;
  logic        res_erro_reg, res_erro_next;

  logic op_invalido;
  logic div_zero;

  // Error classification looks at the registered opcode/operand the ALU is actually computing on.
  assign op_invalido = (ula_sel_reg == 4'd5) || (ula_sel_reg >= 4'd12);
  assign div_zero    = ((ula_sel_reg == 4'd3) || (ula_sel_reg == 4'd4)) && (ula_b_reg == 8'h00);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= OCIOSO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_reg       <= 4'd0;
      acc_reg       <= 8'h00;
      ula_a_reg     <= 8'h00;
      ula_b_reg     <= 8'h00;
      ula_sel_reg   <= 4'd0;
      res_dado_reg  <= 16'h0000;
      res_flags_reg <= 3'b000;
      res_erro_reg  <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      ula_a_reg     <= ula_a_next;
      ula_b_reg     <= ula_b_next;
      ula_sel_reg   <= ula_sel_next;
      res_dado_reg  <= res_dado_next;
      res_flags_reg <= res_flags_next;
      res_erro_reg  <= res_erro_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    ula_a_next     = ula_a_reg;
    ula_b_next     = ula_b_reg;
    ula_sel_next   = ula_sel_reg;
    res_dado_next  = res_dado_reg;
    res_flags_next = res_flags_reg;
    res_erro_next  = res_erro_reg;

    case (state_reg)
      OCIOSO: begin
        if (Cmd_Valido) begin
          case (Cmd_Fonte)
            2'b00: begin
              ula_a_next   = acc_reg;
              ula_b_next   = Cmd_Dado;
              ula_sel_next = Cmd_Op;
              cnt_next     = LAT_CNT;
              state_next   = EXECUTA;
            end
            2'b01: begin
              ula_a_next   = Cmd_Dado;
              ula_b_next   = acc_reg;
              ula_sel_next = Cmd_Op;
              cnt_next     = LAT_CNT;
              state_next   = EXECUTA;
            end
            2'b10: begin
              acc_next       = Cmd_Dado;
              res_dado_next  = {8'h00, Cmd_Dado};
              res_flags_next = 3'b000;
              res_erro_next  = 1'b0;
              state_next     = ENTREGA;
            end
            default: begin
              acc_next       = 8'h00;
              res_dado_next  = 16'h0000;
              res_flags_next = 3'b000;
              res_erro_next  = 1'b0;
              state_next     = ENTREGA;
            end
          endcase
        end
      end

      EXECUTA: begin
        // Capture on the edge where the countdown hits zero, i.e. LATENCIA_ULA edges after accept.
        if (cnt_reg <= 4'd1) begin
          cnt_next       = 4'd0;
          res_flags_next = {ULA_Maior, ULA_Menor, ULA_Igual};
          if (op_invalido || div_zero) begin
            res_dado_next = 16'h0000;
            res_erro_next = 1'b1;
          end else begin
            res_dado_next = ULA_Resultado;
            res_erro_next = 1'b0;
            acc_next      = ULA_Resultado[7:0];
          end
          state_next = ENTREGA;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ENTREGA: begin
        if (Res_Pronto) begin
          state_next = OCIOSO;
        end
      end

      default: begin
        state_next = OCIOSO;
      end
    endcase
  end

  assign Cmd_Pronto = (state_reg == OCIOSO);
  assign Res_Valido = (state_reg == ENTREGA);
  assign ULA_A      = ula_a_reg;
  assign ULA_B      = ula_b_reg;
  assign ULA_Sel    = ula_sel_reg;
  assign Res_Dado   = res_dado_reg;
  assign Res_Flags  = res_flags_reg;
  assign Res_Erro   = res_erro_reg;
  assign Acc        = acc_reg;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Scoreboard bench: two sequencer lanes (settle time 1 and 4) driven by directed and random
// commands, with a behavioural ALU and an accumulator model predicting every result beat.
module tb_sequenciador_ula;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] dado;
    logic [2:0]  flags;
    logic        erro;
    logic [7:0]  acc;
    int          t_acc;
    int          lat;
  } exp_t;

  // Behavioural ALU: add/sub wrap to 8 bits, multiply is full 16-bit, bad opcodes give junk.
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r8;
    logic [15:0] r;
    r8 = 8'h00;
    r  = 16'hBEEF;
    case (op)
      4'd0:  begin r8 = a + b;   r = {8'h00, r8}; end
      4'd1:  begin r8 = a - b;   r = {8'h00, r8}; end
      4'd2:  r = {8'h00, a} * {8'h00, b};
      4'd3:  r = (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
      4'd4:  r = (b == 8'h00) ? 16'hFFFF : {8'h00, a % b};
      4'd6:  r = {8'h00, a & b};
      4'd7:  r = {8'h00, a | b};
      4'd8:  r = {8'h00, ~(a & b)};
      4'd9:  r = {8'h00, ~(a | b)};
      4'd10: r = {8'h00, a ^ b};
      4'd11: r = {8'h00, ~a};
      default: r = 16'hBEEF;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input int lane, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s lane%0d t=%0d: got %0h, required %0h", nm, lane, cyc, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int L = (gi == 0) ? 1 : 4;

    logic        rst_n, cmd_valido, cmd_pronto, res_valido, res_pronto, res_erro;
    logic [3:0]  cmd_op, ula_sel;
    logic [1:0]  cmd_fonte;
    logic [7:0]  cmd_dado, ula_a, ula_b, acc;
    logic [15:0] ula_res, res_dado;
    logic        ula_maior, ula_menor, ula_igual;
    logic [2:0]  res_flags;

    exp_t       q[$];
    logic [7:0] acc_m;
    bit         hold;

    always_comb begin
      ula_res   = alu_ref(ula_sel, ula_a, ula_b);
      ula_maior = ula_a > ula_b;
      ula_menor = ula_a < ula_b;
      ula_igual = ula_a == ula_b;
    end

    sequenciador_ula #(.LATENCIA_ULA(L)) dut (
      .Clk(clk), .Rst_n(rst_n),
      .Cmd_Valido(cmd_valido), .Cmd_Pronto(cmd_pronto),
      .Cmd_Op(cmd_op), .Cmd_Fonte(cmd_fonte), .Cmd_Dado(cmd_dado),
      .ULA_A(ula_a), .ULA_B(ula_b), .ULA_Sel(ula_sel),
      .ULA_Resultado(ula_res), .ULA_Maior(ula_maior), .ULA_Menor(ula_menor), .ULA_Igual(ula_igual),
      .Res_Valido(res_valido), .Res_Pronto(res_pronto),
      .Res_Dado(res_dado), .Res_Flags(res_flags), .Res_Erro(res_erro), .Acc(acc)
    );

    // Issue one command; returns one time step after the accepting edge.
    task automatic issue(input logic [1:0] f, input logic [3:0] op, input logic [7:0] d);
      exp_t e;
      logic [7:0] a, b;
      logic [15:0] r;
      int w;
      cmd_fonte = f; cmd_op = op; cmd_dado = d; cmd_valido = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_pronto && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!cmd_pronto) begin
        chk("accept_timeout", gi, 32'(cmd_pronto), 32'd1);
        cmd_valido = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        cmd_valido = 1'b0;
        e.t_acc = cyc;
        if (f[1]) begin
          acc_m   = f[0] ? 8'h00 : d;
          e.dado  = {8'h00, acc_m};
          e.flags = 3'b000;
          e.erro  = 1'b0;
          e.lat   = 0;
        end else begin
          a = f[0] ? d : acc_m;
          b = f[0] ? acc_m : d;
          chk("ula_a", gi, 32'(ula_a), 32'(a));
          chk("ula_b", gi, 32'(ula_b), 32'(b));
          chk("ula_sel", gi, 32'(ula_sel), 32'(op));
          e.flags = {a > b, a < b, a == b};
          e.lat   = L;
          if (op == 4'd5 || op >= 4'd12 || ((op == 4'd3 || op == 4'd4) && b == 8'h00)) begin
            e.dado = 16'h0000;
            e.erro = 1'b1;
          end else begin
            r      = alu_ref(op, a, b);
            acc_m  = r[7:0];
            e.dado = r;
            e.erro = 1'b0;
          end
        end
        e.acc = acc_m;
        q.push_back(e);
      end
    endtask

    task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk);
      while ((q.size() != 0 || res_valido) && w < 400) begin
        @(negedge clk);
        w++;
      end
      chk("idle_timeout", gi, 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
    endtask

    // Consumer back-pressure.
    initial begin
      res_pronto = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (!hold) res_pronto = ($urandom_range(0, 3) != 0);
      end
    end

    // Monitor: pops and compares on the first cycle of every result beat, then checks stability.
    initial begin
      exp_t cur;
      bit was_v;
      logic [15:0] h_dado;
      logic [2:0]  h_flags;
      logic        h_erro;
      was_v = 0;
      forever begin
        @(negedge clk);
        if (rst_n && res_valido) begin
          chk("pronto_in_entrega", gi, 32'(cmd_pronto), 32'd0);
          if (!was_v) begin
            if (q.size() == 0) begin
              chk("spurious_valid", gi, 32'(res_valido), 32'd0);
            end else begin
              cur = q.pop_front();
              chk("latency", gi, 32'(cyc - cur.t_acc), 32'(cur.lat));
              chk("res_dado", gi, 32'(res_dado), 32'(cur.dado));
              chk("res_flags", gi, 32'(res_flags), 32'(cur.flags));
              chk("res_erro", gi, 32'(res_erro), 32'(cur.erro));
              chk("acc", gi, 32'(acc), 32'(cur.acc));
              $display("lane%0d t=%0d result dado=%h flags=%b erro=%b acc=%h", gi, cyc, res_dado, res_flags, res_erro, acc);
            end
            h_dado = res_dado; h_flags = res_flags; h_erro = res_erro;
          end else begin
            chk("hold_dado", gi, 32'(res_dado), 32'(h_dado));
            chk("hold_flags_erro", gi, 32'({res_flags, res_erro}), 32'({h_flags, h_erro}));
          end
          was_v = !res_pronto;
        end else begin
          was_v = 0;
        end
      end
    end

    initial begin
      int r;
      logic [1:0] f;
      logic [7:0] d;
      rst_n = 1'b0; cmd_valido = 1'b0; cmd_op = 4'd0; cmd_fonte = 2'd0; cmd_dado = 8'd0;
      hold = 0; acc_m = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_acc", gi, 32'(acc), 32'd0);
      chk("rst_ula", gi, 32'({ula_a, ula_b, ula_sel}), 32'd0);
      chk("rst_res", gi, 32'({res_valido, res_dado, res_flags, res_erro}), 32'd0);
      chk("rst_pronto", gi, 32'(cmd_pronto), 32'd1);
      @(posedge clk);
      #1;

      if (gi == 0) begin
        issue(2'b10, 4'd0, 8'd20);
        issue(2'b00, 4'd0, 8'd250);
        issue(2'b10, 4'd0, 8'd200);
        issue(2'b00, 4'd2, 8'd3);
        issue(2'b10, 4'd0, 8'd7);
        issue(2'b00, 4'd3, 8'd0);
        issue(2'b00, 4'd12, 8'd0);
        issue(2'b11, 4'd0, 8'd99);
        // Stall the consumer; a command pulse during the stall must be dropped.
        wait_idle();
        hold = 1;
        res_pronto = 1'b0;
        issue(2'b10, 4'd0, 8'hA5);
        for (int i = 0; i < 5; i++) begin
          cmd_valido = (i == 1);
          cmd_fonte = 2'b10;
          cmd_dado = 8'h33;
          @(negedge clk);
          chk("stall_pronto", gi, 32'(cmd_pronto), 32'd0);
          chk("stall_valid", gi, 32'(res_valido), 32'd1);
          @(posedge clk);
          #1;
        end
        cmd_valido = 1'b0;
        res_pronto = 1'b1;
        @(posedge clk);
        #1;
        res_pronto = 1'b0;
        @(negedge clk);
        chk("after_hs_pronto", gi, 32'(cmd_pronto), 32'd1);
        chk("after_hs_valid", gi, 32'(res_valido), 32'd0);
        chk("after_stall_acc", gi, 32'(acc), 32'hA5);
        hold = 0;
        @(posedge clk);
        #1;
      end else begin
        issue(2'b10, 4'd0, 8'd5);
        issue(2'b01, 4'd1, 8'd9);
        // Reset while the ALU command is settling aborts it.
        wait_idle();
        issue(2'b00, 4'd2, 8'($urandom));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        acc_m = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_acc", gi, 32'(acc), 32'd0);
        chk("abort_pronto", gi, 32'(cmd_pronto), 32'd1);
        chk("abort_valid", gi, 32'(res_valido), 32'd0);
        @(posedge clk);
        #1;
      end

      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        f = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        r = $urandom_range(0, 7);
        d = (r == 0) ? 8'h00 : (r == 1) ? acc_m : 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        issue(f, 4'($urandom_range(0, 15)), d);
      end
      wait_idle();
      done_cnt++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (done_cnt < 2 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < 2) chk("global_timeout", 0, 32'(done_cnt), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequenciador_ula.md
# sequenciador_ula

Accumulator-based command sequencer sitting directly upstream of the 8-bit ALU. It accepts one operation command per valid/ready handshake and drives the ALU operand and opcode inputs from registers. After a fixed settle time it captures the ALU's 16-bit result and comparator flags, and delivers them on a valid/ready result port. It also writes the low result byte back into an internal 8-bit accumulator, so chains of operations need no external operand storage.

## Interface
- LATENCIA_ULA, default 1: cycles between driving the ALU inputs and capturing its outputs; legal range 1..15.
- Clk  in  1  single clock; all state changes on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Cmd_Valido  in  1  command present.
- Cmd_Pronto  out  1  sequencer can accept a command.
- Cmd_Op  in  4  ALU opcode: 0 soma, 1 subtração, 2 multiplicação, 3 quociente, 4 resto, 6 AND, 7 OR, 8 NAND, 9 NOR, 10 XOR, 11 NOT.
- Cmd_Fonte  in  2  operand routing (see Operation).
- Cmd_Dado  in  8  immediate operand.
- ULA_A, ULA_B  out  8 each  registered ALU operands.
- ULA_Sel  out  4  registered ALU opcode.
- ULA_Resultado  in  16  ALU result.
- ULA_Maior, ULA_Menor, ULA_Igual  in  1 each  ALU comparator flags.
- Res_Valido  out  1  result beat present.
- Res_Pronto  in  1  consumer accepts result.
- Res_Dado  out  16  captured result.
- Res_Flags  out  3  {Maior, Menor, Igual} captured.
- Res_Erro  out  1  invalid opcode or division by zero.
- Acc  out  8  accumulator value.

## Operation
- FSM states: OCIOSO, EXECUTA, ENTREGA.
- Cmd_Pronto = 1 only in OCIOSO.
- A command is accepted on an edge where Cmd_Valido & Cmd_Pronto.
- Cmd_Fonte routing:
  - 00: ULA_A←Acc, ULA_B←Cmd_Dado, ULA_Sel←Cmd_Op; go to EXECUTA.
  - 01: ULA_A←Cmd_Dado, ULA_B←Acc, ULA_Sel←Cmd_Op; go to EXECUTA.
  - 10 (load): Acc←Cmd_Dado; Res_Dado←{8'h00,Cmd_Dado}; flags 0, Erro 0; go directly to ENTREGA. ULA_* unchanged.
  - 11 (clear): same as 10 with value 8'h00.
- EXECUTA: internal counter loaded with LATENCIA_ULA at accept and decremented each cycle. On the edge where it reaches 0, capture the ALU outputs and go to ENTREGA.
- Capture rules:
  - Valid opcode, not div-by-zero: Res_Dado←ULA_Resultado, Res_Flags←{Maior,Menor,Igual}, Res_Erro←0, Acc←ULA_Resultado[7:0]. For multiplication, Res_Dado carries the full 16-bit product while Acc takes only the low byte.
  - Opcode 5 or 12–15: Res_Dado←0, Res_Flags←captured flags, Res_Erro←1, Acc unchanged.
  - Opcode 3 or 4 with ULA_B==0: Res_Dado←0, Res_Flags←captured flags, Res_Erro←1, Acc unchanged.
- ENTREGA: Res_Valido=1 and Res_Dado/Res_Flags/Res_Erro are held stable until the edge with Res_Pronto=1, then go to OCIOSO.
- ULA_A/ULA_B/ULA_Sel change only at accept of a Fonte 00/01 command and otherwise hold their last values.
- Commands presented while Cmd_Pronto=0 are ignored; no buffering.

## Timing
- Reset (Rst_n=0 at an edge): state OCIOSO, Acc=0, ULA_A=ULA_B=0, ULA_Sel=0, Res_Valido=0, Res_Dado=0, Res_Flags=0, Res_Erro=0, counter 0. Cmd_Pronto=1 from the first cycle after reset is released.
- Reset mid-EXECUTA or mid-ENTREGA aborts the command: no result beat is delivered and Acc returns to 0.
- ALU command accepted at edge k: ULA_* valid after k; capture at edge k+LATENCIA_ULA; Res_Valido=1 after that edge.
- Load/clear accepted at edge k: Res_Valido=1 after k.
- Result handshake at edge m: Res_Valido=0 and Cmd_Pronto=1 after m. Next accept earliest at edge m+1.
- Minimum period with LATENCIA_ULA=1 and Res_Pronto tied high: 3 cycles per ALU command, 2 per load/clear.
- Res_Pronto asserted while Res_Valido=0 has no effect.

## Test plan
- Load 8'd20 (Fonte 10), then Fonte 00 op 0 with Dado 8'd250 → Res_Dado 16'h000E, Acc 8'h0E, Erro 0, Res_Valido 1 cycle after the second accept (LATENCIA_ULA=1).
- Load 8'd200, Fonte 00 op 2 Dado 8'd3 → Res_Dado 16'h0258, Acc 8'h58, Res_Flags 3'b100.
- Load 8'd7, Fonte 00 op 3 Dado 0 → Res_Erro 1, Res_Dado 0, Acc stays 8'd7. Repeat with op 12 → same error behaviour.
- Hold Res_Pronto=0 for 5 cycles after a result → Res_Valido and Res_Dado stable, Cmd_Pronto 0, a new command pulse is ignored. After Res_Pronto=1, Cmd_Pronto=1 on the next cycle.
- LATENCIA_ULA=4, Fonte 01 op 1, Acc=8'd5, Dado 8'd9 → ULA_A=9, ULA_B=5; capture exactly 4 edges after accept; Res_Dado 16'h0004, Acc 8'h04.
- Assert Rst_n=0 during EXECUTA → no Res_Valido pulse, Acc=0, Cmd_Pronto=1 after release.
